// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execution unit: one-cycle arithmetic/logic ops, bit-serial shifts.
// Optional SLT/SLTU support is enabled by defining ALU_SLT_EN.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [6:0]         funct7,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [3:0] {
        OpAdd, OpSub, OpXor, OpOr, OpAnd, OpSll, OpSrl, OpSra, OpSlt, OpSltu, OpIll
    } op_e;

    state_e             state;
    op_e                dec_op;
    op_e                shift_op;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_val;
    logic [XLEN-1:0]    step;
    logic               r_type;
    logic               f7_zero;
    logic               f7_alt;
    logic               is_shift;

    assign r_type   = (alu_op == 2'b10);
    assign f7_zero  = (funct7 == 7'h00);
    assign f7_alt   = (funct7 == 7'h20);
    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (dec_op == OpSll) || (dec_op == OpSrl) || (dec_op == OpSra);

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

    always_comb begin
        dec_op = OpIll;
        case (alu_op)
            2'b00: dec_op = OpAdd;
            2'b01: dec_op = OpSub;
            default: begin
                case (funct3)
                    3'd0: begin
                        if (!r_type || f7_zero) dec_op = OpAdd;
                        else if (f7_alt)        dec_op = OpSub;
                    end
                    3'd1: if (f7_zero) dec_op = OpSll;
`ifdef ALU_SLT_EN
                    3'd2: if (!r_type || f7_zero) dec_op = OpSlt;
                    3'd3: if (!r_type || f7_zero) dec_op = OpSltu;
`endif
                    3'd4: dec_op = OpXor;
                    3'd5: begin
                        if (f7_zero)     dec_op = OpSrl;
                        else if (f7_alt) dec_op = OpSra;
                    end
                    3'd6: dec_op = OpOr;
                    3'd7: dec_op = OpAnd;
                    default: dec_op = OpIll;
                endcase
            end
        endcase
    end

    // Shifts load op_a unchanged; the SHIFT state then walks it one bit per cycle.
    always_comb begin
        alu_val = '0;
        case (dec_op)
            OpAdd:  alu_val = op_a + op_b;
            OpSub:  alu_val = op_a - op_b;
            OpXor:  alu_val = op_a ^ op_b;
            OpOr:   alu_val = op_a | op_b;
            OpAnd:  alu_val = op_a & op_b;
            OpSlt:  alu_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpSltu: alu_val = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OpSll, OpSrl, OpSra: alu_val = op_a;
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        case (shift_op)
            OpSll:   step = {result[XLEN-2:0], 1'b0};
            OpSrl:   step = {1'b0, result[XLEN-1:1]};
            default: step = {result[XLEN-1], result[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            result   <= '0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
            cnt      <= '0;
            shift_op <= OpSll;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        result   <= alu_val;
                        illegal  <= (dec_op == OpIll);
                        shift_op <= dec_op;
                        if (is_shift && (shamt != '0)) begin
                            cnt   <= shamt;
                            state <= StShift;
                        end else begin
                            zero  <= (alu_val == '0);
                            state <= StDone;
                        end
                    end
                end
                StShift: begin
                    result <= step;
                    cnt    <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        zero  <= (step == '0);
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a behavioural reference model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result, illegal flag and latency straight from the instruction semantics.
    function automatic void model(input logic [1:0] op, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int n;
        bit rt, f0, f20;
        n   = int'(b[4:0]);
        rt  = (op == 2'b10);
        f0  = (f7 == 7'h00);
        f20 = (f7 == 7'h20);
        r   = 0;
        ill = 1'b0;
        lat = 1;
        if (op == 2'b00)      r = a + b;
        else if (op == 2'b01) r = a - b;
        else begin
            case (f3)
                3'd0: if (!rt || f0) r = a + b; else if (f20) r = a - b; else ill = 1'b1;
                3'd1: if (f0) begin r = a << n; lat = 1 + n; end else ill = 1'b1;
`ifdef ALU_SLT_EN
                3'd2: if (!rt || f0) r = ($signed(a) < $signed(b)) ? 1 : 0; else ill = 1'b1;
                3'd3: if (!rt || f0) r = (a < b) ? 1 : 0; else ill = 1'b1;
`else
                3'd2, 3'd3: ill = 1'b1;
`endif
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f0)       begin r = a >> n; lat = 1 + n; end
                    else if (f20) begin r = $signed(a) >>> n; lat = 1 + n; end
                    else ill = 1'b1;
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        in_valid = 1'b1;
        alu_op   = op;
        funct7   = f7;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ei;
        int          el;
        int          lat;
        bit          busy_ok;
        model(op, f7, f3, a, b, er, ei, el);
        drive_req(op, f7, f3, a, b);
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            // Junk requests while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            alu_op   = 2'($urandom);
            funct3   = 3'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " zero"}, 64'(zero), 64'(er == 0));
        check({tag, " illegal"}, 64'(illegal), 64'(ei));
        check({tag, " busy in_ready"}, 64'(busy_ok), 64'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle in_ready"}, 64'(in_ready), 64'(1));
        check({tag, " idle out_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] er;
        logic        ei;
        int          el;
        bit          stable;
        bit          seen;
        int          guard;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        funct7    = '0;
        funct3    = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset zero", 64'(zero), 64'(0));
        check("reset illegal", 64'(illegal), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        run_op("sub_r", 2'b10, 7'h20, 3'd0, 32'd5, 32'd7);
        run_op("sra_i", 2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'd4);
        run_op("sll_zero", 2'b10, 7'h00, 3'd1, 32'h1234_5678, 32'd0);
        run_op("sll_32", 2'b10, 7'h00, 3'd1, 32'h1234_5678, 32'd32);
        run_op("slt", 2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu_i", 2'b11, 7'h55, 3'd3, 32'd3, 32'hFFFF_FFF0);
        run_op("sll_bad_f7", 2'b10, 7'h20, 3'd1, 32'd9, 32'd3);
        run_op("add_bad_f7", 2'b10, 7'h01, 3'd0, 32'd9, 32'd3);
        run_op("addi_any_f7", 2'b11, 7'h7F, 3'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("sll_31", 2'b11, 7'h00, 3'd1, 32'h0000_0003, 32'd31);
        run_op("ld_add", 2'b00, 7'h3C, 3'd5, 32'h7FFF_FFFF, 32'd1);
        run_op("br_sub", 2'b01, 7'h00, 3'd2, 32'd4, 32'd4);

        for (int i = 0; i < 40; i++) begin
            logic [6:0] f7;
            logic [31:0] b;
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
            run_op($sformatf("rand%0d", i), 2'($urandom), f7, 3'($urandom), $urandom, b);
        end

        // Result must hold while the consumer stalls.
        model(2'b10, 7'h00, 3'd7, 32'hF0F0_1234, 32'h0FF0_00FF, er, ei, el);
        drive_req(2'b10, 7'h00, 3'd7, 32'hF0F0_1234, 32'h0FF0_00FF);
        r0     = result;
        stable = out_valid;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = $urandom;
            op_b     = $urandom;
            @(negedge clk);
            if (!out_valid || result !== r0 || zero !== (r0 == 0)) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("stall result", 64'(result), 64'(er));
        check("stall stable", 64'(stable), 64'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall release in_ready", 64'(in_ready), 64'(1));

        // Reset in the middle of a long shift discards it.
        drive_req(2'b10, 7'h00, 3'd5, $urandom | 32'h8000_0000, 32'd20);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'(0));
        check("midreset result", 64'(result), 64'(0));
        check("midreset illegal", 64'(illegal), 64'(0));
        check("midreset in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        guard = 0;
        while (guard < 30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            guard++;
        end
        check("no result after reset", 64'(seen), 64'(0));
        run_op("after_reset", 2'b10, 7'h20, 3'd5, 32'h8000_00F0, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have derived parameter SHAMT_W, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 alu_op  input  2  class: 00 load/store, 01 branch, 10 R-type arith, 11 I-type arith.
REQ-008 funct7  input  7  instruction funct7 (I-type: imm[11:5]).
REQ-009 funct3  input  3  instruction funct3.
REQ-010 op_a  input  XLEN  first operand.
REQ-011 op_b  input  XLEN  second operand or immediate; shift amount is op_b[SHAMT_W-1:0].
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  registered result.
REQ-015 zero  output  1  registered (result == 0); meaningful only while out_valid.
REQ-016 illegal  output  1  registered flag: request encoding unsupported.

Function
REQ-017 Decode SHALL be: 00 -> ADD; 01 -> SUB; 10 funct3 0 -> ADD if funct7=0x00, SUB if 0x20; 10/11 funct3 4/6/7 -> XOR/OR/AND; funct3 1 -> SLL (funct7 must be 0x00); funct3 5 -> SRL if funct7=0x00, SRA if 0x20; 11 funct3 0 -> ADD for any funct7.
REQ-018 Any encoding not listed in REQ-017 (bad funct7, unsupported funct3) SHALL complete with latency 1, result 0, illegal 1.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-020 Request is accepted on a rising edge with in_valid && in_ready; operands and decoded op are captured at that edge.
REQ-021 Non-shift ops (including illegal) SHALL go IDLE -> DONE on the accept edge: latency 1 cycle.
REQ-022 Shifts with amount n: n = 0 -> DONE at accept edge; n > 0 -> SHIFT with counter = n, one-bit shift per cycle, DONE on the edge the counter reaches 0; latency 1+n cycles.
REQ-023 SRA SHALL replicate op_a[XLEN-1] into vacated bits every step; SLL/SRL SHALL fill with 0; op_b bits above SHAMT_W-1 are ignored.
REQ-024 ADD/SUB SHALL wrap modulo 2^XLEN; no carry/overflow output.
REQ-025 In DONE, result/zero/illegal SHALL hold stable until out_valid && out_ready; that edge returns to IDLE.
REQ-026 No request SHALL be accepted in the cycle a result is consumed; minimum issue interval is latency+1 cycles.
REQ-027 in_valid and input fields SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, result 0, zero 0, illegal 0, out_valid 0, shift counter 0.
REQ-029 Reset asserted mid-shift or while DONE SHALL discard the operation; no result is produced after release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro ALU_SLT_EN defined: funct3 2 -> SLT (signed), funct3 3 -> SLTU (unsigned) for alu_op 10 (funct7=0x00) and 11 (any funct7); result is zero-extended 0/1, latency 1.
REQ-032 Macro ALU_SLT_EN undefined: funct3 2/3 SHALL be treated as illegal per REQ-018.

Verification
REQ-033 Reset release, alu_op=10, funct3=0, funct7=0x20, op_a=5, op_b=7 -> out_valid 1 cycle after accept, result=0xFFFFFFFE, zero 0, illegal 0.
REQ-034 alu_op=11, funct3=5, funct7=0x20, op_a=0x80000000, op_b=4 -> out_valid 5 cycles after accept, result=0xF8000000; in_ready 0 throughout.
REQ-035 alu_op=10, funct3=1, funct7=0x00, op_b=0 -> latency 1, result=op_a; op_b=32 (shamt 0) -> same result.
REQ-036 out_ready held 0 for 10 cycles in DONE -> result/zero stable, in_valid pulses ignored; out_ready 1 -> IDLE next cycle, in_ready 1.
REQ-037 alu_op=10, funct3=2, op_a=-1, op_b=1 -> with ALU_SLT_EN result=1, illegal 0; without, result=0, illegal 1.
REQ-038 rst_n pulsed low during SHIFT with op_b=20 -> outputs zeroed at once, no out_valid after release, next request processes normally.
